// File: rtl/countdown_pkg.sv
// Shared types and helpers for the BCD game countdown timer.
// The optional warning output is enabled with the COUNTDOWN_WARN_EN macro.
package countdown_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  // Non-decimal nibbles (A-F) load as 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decade of the BCD down-counter: loads a value or decrements with borrow.
module bcd_digit_down
  import countdown_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec_en,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit,
  output logic             is_zero,
  output logic             borrow_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec_en && borrow_in) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - BCD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign is_zero    = (digit_q == '0);
  assign borrow_out = dec_en & borrow_in & is_zero;

endmodule

// File: rtl/game_countdown_timer.sv
// BCD round countdown driven by the rate-divider tick; flags expiry to game control.
// Define COUNTDOWN_WARN_EN to add the Warn output for the low-count warning.
module game_countdown_timer
  import countdown_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int WARN_THRESHOLD = 5
) (
  input  logic                        ClockIn,
  input  logic                        Reset,
  input  logic                        Tick,
  input  logic                        Start,
  input  logic                        Pause,
  input  logic [BCD_W*NUM_DIGITS-1:0] LoadValue,
  output logic [BCD_W*NUM_DIGITS-1:0] Digits,
  output logic                        Running,
  output logic                        Expired,
  output logic                        DonePulse
`ifdef COUNTDOWN_WARN_EN
  ,
  output logic                        Warn
`endif
);

  localparam int CNT_W = BCD_W * NUM_DIGITS;

  // Handshake: Tick, Start and Pause are sampled every rising edge with
  // priority Start > Pause > Tick; there is no ready/back-pressure path.
  state_e           state_q, state_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0]      load_clamped;
  logic [NUM_DIGITS-1:0] digit_zero;
  logic [NUM_DIGITS:0]   borrow;
  logic                  load_zero;
  logic                  cnt_zero;
  logic                  cnt_one;
  logic                  dec_en;

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign load_clamped[g*BCD_W +: BCD_W] = bcd_clamp(LoadValue[g*BCD_W +: BCD_W]);

    bcd_digit_down u_digit (
      .clk        (ClockIn),
      .rst_n      (Reset),
      .load       (Start),
      .load_val   (load_clamped[g*BCD_W +: BCD_W]),
      .dec_en     (dec_en),
      .borrow_in  (borrow[g]),
      .digit      (Digits[g*BCD_W +: BCD_W]),
      .is_zero    (digit_zero[g]),
      .borrow_out (borrow[g+1])
    );
  end

  assign load_zero = (load_clamped == '0);
  assign cnt_zero  = &digit_zero;
  assign cnt_one   = (Digits == CNT_W'(1));
  assign dec_en    = (state_q == RUN) && !Start && !Pause && Tick && !cnt_zero;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (Start) begin
      if (Pause) begin
        state_d = PAUSE;
      end else if (load_zero) begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          // A zero count can only reach RUN by resuming a paused zero load.
          if (Pause) begin
            state_d = PAUSE;
          end else if (cnt_zero || (Tick && cnt_one)) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end
        end
        PAUSE: begin
          if (!Pause) state_d = RUN;
        end
        default: ;
      endcase
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign Running   = running_q;
  assign Expired   = expired_q;
  assign DonePulse = done_q;

`ifdef COUNTDOWN_WARN_EN
  logic warn_q, warn_d;
  int   cnt_bin;
  int   load_bin;
  logic cur_in_range;
  logic next_in_range;
  logic load_in_range;

  function automatic int bcd_to_bin(input logic [CNT_W-1:0] v);
    int acc;
    acc = 0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc = acc * 10 + int'(v[i*BCD_W +: BCD_W]);
    end
    return acc;
  endfunction

  assign cnt_bin       = bcd_to_bin(Digits);
  assign load_bin      = bcd_to_bin(load_clamped);
  assign cur_in_range  = (cnt_bin != 0) && (cnt_bin <= WARN_THRESHOLD);
  assign next_in_range = (cnt_bin > 1) && ((cnt_bin - 1) <= WARN_THRESHOLD);
  assign load_in_range = (load_bin != 0) && (load_bin <= WARN_THRESHOLD);

  always_comb begin
    warn_d = warn_q;
    if ((state_d == RUN) || (state_d == PAUSE)) begin
      if (Start) begin
        warn_d = load_in_range;
      end else if (dec_en) begin
        // Entering the range forces 1; later decrements inside it toggle.
        warn_d = !next_in_range ? 1'b0 : (cur_in_range ? ~warn_q : 1'b1);
      end
    end else begin
      warn_d = 1'b0;
    end
  end

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign Warn = warn_q;
`endif

endmodule
